// File: rtl/gfx_addr_pkg.sv
// Shared definitions for the rectangle addressing engine: FSM state encoding,
// default screen geometry and a constant-evaluable clog2.
package gfx_addr_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ROW_IDX    = 2'd1,
    START_ADDR = 2'd2,
    STREAM     = 2'd3
  } state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_BPP      = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rect_addr_engine_if.sv
// Command and address-stream bundle for rect_addr_engine; the engine is the
// slave, the command source / address consumer is the master.
interface rect_addr_engine_if #(
  parameter int COORD_W = 16,
  parameter int ADDR_W  = 17,
  parameter int BIT_W   = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_origx;
  logic [COORD_W-1:0] cmd_origy;
  logic [COORD_W-1:0] cmd_width;
  logic [COORD_W-1:0] cmd_height;
  logic               addr_valid;
  logic               addr_ready;
  logic [ADDR_W-1:0]  addr_word;
  logic [BIT_W-1:0]   addr_bit;
  logic               addr_eol;
  logic               addr_last;
  logic               busy;
  logic               err;

  modport slave (
    input  cmd_valid, cmd_origx, cmd_origy, cmd_width, cmd_height, addr_ready,
    output cmd_ready, addr_valid, addr_word, addr_bit, addr_eol, addr_last, busy, err
  );

  modport master (
    output cmd_valid, cmd_origx, cmd_origy, cmd_width, cmd_height, addr_ready,
    input  cmd_ready, addr_valid, addr_word, addr_bit, addr_eol, addr_last, busy, err
  );
endinterface

// File: rtl/rect_step_counter.sv
// Column/row position inside the rectangle being streamed; flags the last
// pixel of a row (eol) and of the whole rectangle (last).
module rect_step_counter #(
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               clear,
  input  logic               step,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  output logic               eol,
  output logic               last
);
  logic [COORD_W-1:0] col_reg;
  logic [COORD_W-1:0] row_reg;

  assign eol  = (col_reg == width - COORD_W'(1));
  assign last = eol && (row_reg == height - COORD_W'(1));

  always_ff @(posedge clk) begin
    if (rst_ || clear) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (step) begin
      if (eol) begin
        col_reg <= '0;
        row_reg <= row_reg + COORD_W'(1);
      end else begin
        col_reg <= col_reg + COORD_W'(1);
      end
    end
  end
endmodule

// File: rtl/rect_addr_engine.sv
// Streams one packed-pixel (word, bit) address per rectangle pixel, row-major.
// Build option: define CLIP_EN to clip rectangles to the screen instead of rejecting them.
module rect_addr_engine
  import gfx_addr_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int BPP       = DEF_BPP,
  parameter int WORD_BITS = 8,
  parameter int COORD_W   = 16,
  parameter int ADDR_W    = 17
) (
  input  logic            clk,
  input  logic            rst_,
  rect_addr_engine_if.slave bus
);
  localparam int WB_LOG = clog2(WORD_BITS);
  localparam int BIT_W  = (WB_LOG > 0) ? WB_LOG : 1;
  localparam int BW     = ADDR_W + WB_LOG;
  localparam int SW     = COORD_W + 1;
  localparam logic [BW-1:0] ROW_STRIDE = BW'(SCREEN_W * BPP);
  localparam logic [BW-1:0] PIX_STEP   = BW'(BPP);
  localparam logic [BW-1:0] BIT_MASK   = BW'(WORD_BITS - 1);

  state_t state_reg, state_next;

  logic [COORD_W-1:0] origx_reg, origy_reg, width_reg, height_reg;
  logic [BW-1:0]      row_base_reg, row_start_reg, b_reg;
  logic [BW-1:0]      start_bit;
  logic               err_reg;
  logic               cmd_ready, accept, step, eol, last;
  logic               zero_size, off_screen, reject, drop_cmd;
  logic [SW-1:0]      ox_w, oy_w;

  assign ox_w       = SW'(bus.cmd_origx);
  assign oy_w       = SW'(bus.cmd_origy);
  assign zero_size  = (bus.cmd_width == '0) || (bus.cmd_height == '0);
  assign off_screen = (ox_w >= SW'(SCREEN_W)) || (oy_w >= SW'(SCREEN_H));

`ifdef CLIP_EN
  // Off-screen origins are the only way a clipped size can reach zero.
  assign reject   = 1'b0;
  assign drop_cmd = zero_size || off_screen;
`else
  logic [SW-1:0] end_x, end_y;
  assign end_x    = ox_w + SW'(bus.cmd_width);
  assign end_y    = oy_w + SW'(bus.cmd_height);
  assign reject   = !zero_size && (off_screen || (end_x > SW'(SCREEN_W)) || (end_y > SW'(SCREEN_H)));
  assign drop_cmd = zero_size || reject;
`endif

  assign accept    = cmd_ready && bus.cmd_valid;
  assign step      = (state_reg == STREAM) && bus.addr_ready;
  assign start_bit = (row_base_reg + BW'(origx_reg)) * PIX_STEP;

  always_ff @(posedge clk) begin
    if (rst_) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid && !drop_cmd) state_next = ROW_IDX;
      end
      ROW_IDX:    state_next = START_ADDR;
      START_ADDR: state_next = STREAM;
      STREAM:     if (bus.addr_ready && last) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

`ifdef CLIP_EN
  logic [SW-1:0] room_x, room_y;
  assign room_x = SW'(SCREEN_W) - SW'(origx_reg);
  assign room_y = SW'(SCREEN_H) - SW'(origy_reg);
`endif

  always_ff @(posedge clk) begin
    if (rst_) begin
      origx_reg     <= '0;
      origy_reg     <= '0;
      width_reg     <= '0;
      height_reg    <= '0;
      row_base_reg  <= '0;
      row_start_reg <= '0;
      b_reg         <= '0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= accept && reject;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            origx_reg  <= bus.cmd_origx;
            origy_reg  <= bus.cmd_origy;
            width_reg  <= bus.cmd_width;
            height_reg <= bus.cmd_height;
          end
        end
        ROW_IDX: begin
          row_base_reg <= BW'(origy_reg) * BW'(SCREEN_W);
`ifdef CLIP_EN
          if (SW'(width_reg) > room_x)  width_reg  <= room_x[COORD_W-1:0];
          if (SW'(height_reg) > room_y) height_reg <= room_y[COORD_W-1:0];
`endif
        end
        START_ADDR: begin
          b_reg         <= start_bit;
          row_start_reg <= start_bit;
        end
        STREAM: begin
          // Row wrap restarts from the saved row origin rather than re-multiplying.
          if (bus.addr_ready) begin
            if (eol) begin
              row_start_reg <= row_start_reg + ROW_STRIDE;
              b_reg         <= row_start_reg + ROW_STRIDE;
            end else begin
              b_reg <= b_reg + PIX_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  rect_step_counter #(.COORD_W(COORD_W)) u_step (
    .clk    (clk),
    .rst_   (rst_),
    .clear  (state_reg == START_ADDR),
    .step   (step),
    .width  (width_reg),
    .height (height_reg),
    .eol    (eol),
    .last   (last)
  );

  assign bus.cmd_ready  = cmd_ready;
  assign bus.addr_valid = (state_reg == STREAM);
  assign bus.addr_word  = ADDR_W'(b_reg >> WB_LOG);
  assign bus.addr_bit   = BIT_W'(b_reg & BIT_MASK);
  assign bus.addr_eol   = (state_reg == STREAM) && eol;
  assign bus.addr_last  = (state_reg == STREAM) && last;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.err        = err_reg;
endmodule

// File: tb/tb_rect_addr_engine.sv
// Directed plus randomized bench for rect_addr_engine; expected addresses come
// from a pixel-by-pixel arithmetic model of the rectangle.
module tb_rect_addr_engine;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int PBPP  = 3;
  localparam int WBITS = 8;

  typedef struct {
    int x;
    int y;
    int word;
    int bitp;
    bit eol;
    bit last;
  } px_t;

  logic clk;
  logic rst_;
  int   n_cmp;
  int   n_bad;
  px_t  exp_q[$];

  rect_addr_engine_if #(.COORD_W(16), .ADDR_W(17), .BIT_W(3)) bus ();

  rect_addr_engine dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: enumerate pixels of the (possibly clipped) rectangle.
  task automatic build_model(input int ox, input int oy, input int w, input int h, output bit exp_err);
    int ew, eh, b;
    px_t p;
    exp_q.delete();
    exp_err = 1'b0;
    ew = w;
    eh = h;
`ifdef CLIP_EN
    if (ox >= SCR_W || oy >= SCR_H) return;
    if (ew > SCR_W - ox) ew = SCR_W - ox;
    if (eh > SCR_H - oy) eh = SCR_H - oy;
`else
    if (w == 0 || h == 0) return;
    if (ox >= SCR_W || oy >= SCR_H || ox + w > SCR_W || oy + h > SCR_H) begin
      exp_err = 1'b1;
      return;
    end
`endif
    if (ew == 0 || eh == 0) return;
    for (int y = oy; y < oy + eh; y++) begin
      for (int x = ox; x < ox + ew; x++) begin
        b      = (y * SCR_W + x) * PBPP;
        p.x    = x;
        p.y    = y;
        p.word = b / WBITS;
        p.bitp = b % WBITS;
        p.eol  = (x == ox + ew - 1);
        p.last = p.eol && (y == oy + eh - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic run_cmd(input int ox, input int oy, input int w, input int h,
                         input int rmode, input int abort_at);
    bit exp_err, seen, held, phase;
    logic r;
    int cyc, n_hs;
    px_t p;
    logic [16:0] h_word;
    logic [2:0]  h_bit;
    logic        h_eol, h_last;

    build_model(ox, oy, w, h, exp_err);
    $display("cmd origin=(%0d,%0d) size=%0dx%0d mode=%0d expect_addrs=%0d expect_err=%0d",
             ox, oy, w, h, rmode, exp_q.size(), exp_err);
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_origx  = 16'(ox);
    bus.cmd_origy  = 16'(oy);
    bus.cmd_width  = 16'(w);
    bus.cmd_height = 16'(h);
    bus.cmd_valid  = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("err_pulse", bus.err, 32'(exp_err));

    if (exp_q.size() == 0) begin
      repeat (4) begin
        @(negedge clk);
        chk("no_output", bus.addr_valid, 0);
        chk("err_one_cycle", bus.err, 0);
      end
      chk("idle_after_drop", bus.busy, 0);
      return;
    end

    cyc = 1; seen = 0; held = 0; n_hs = 0; phase = 1;
    h_word = '0; h_bit = '0; h_eol = 0; h_last = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      if (bus.addr_valid && !seen) begin
        seen = 1;
        chk("first_addr_latency", cyc, 3);
      end
      if (held) begin
        chk("hold_valid", bus.addr_valid, 1);
        chk("hold_word", bus.addr_word, h_word);
        chk("hold_bit", bus.addr_bit, h_bit);
        chk("hold_eol", bus.addr_eol, h_eol);
        chk("hold_last", bus.addr_last, h_last);
      end
      if (abort_at >= 0 && bus.addr_valid && n_hs == abort_at) begin
        p = exp_q[0];
        chk("pre_reset_word", bus.addr_word, p.word);
        rst_ = 1'b1;
        bus.addr_ready = 1'b0;
        @(negedge clk);
        rst_ = 1'b0;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_addr_valid", bus.addr_valid, 0);
        chk("rst_word", bus.addr_word, 0);
        chk("rst_bit", bus.addr_bit, 0);
        chk("rst_eol", bus.addr_eol, 0);
        chk("rst_last", bus.addr_last, 0);
        chk("rst_err", bus.err, 0);
        $display("reset applied mid-stream after %0d addresses", n_hs);
        exp_q.delete();
        repeat (3) begin
          @(negedge clk);
          chk("no_output_after_rst", bus.addr_valid, 0);
        end
        return;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = phase;
        default: r = 1'($urandom_range(0, 1));
      endcase
      phase = !phase;
      bus.addr_ready = r;
      held = 0;
      if (bus.addr_valid) begin
        if (r) begin
          p = exp_q.pop_front();
          chk("addr_word", bus.addr_word, p.word);
          chk("addr_bit", bus.addr_bit, p.bitp);
          chk("addr_eol", bus.addr_eol, 32'(p.eol));
          chk("addr_last", bus.addr_last, 32'(p.last));
          $display("addr px=(%0d,%0d) word=%0d bit=%0d eol=%0d last=%0d",
                   p.x, p.y, bus.addr_word, bus.addr_bit, bus.addr_eol, bus.addr_last);
          n_hs++;
        end else begin
          held   = 1;
          h_word = bus.addr_word;
          h_bit  = bus.addr_bit;
          h_eol  = bus.addr_eol;
          h_last = bus.addr_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.addr_ready = 1'b0;
    chk("stream_complete_remaining", exp_q.size(), 0);
    chk("valid_after_last", bus.addr_valid, 0);
    chk("cmd_ready_after_last", bus.cmd_ready, 1);
    chk("busy_after_last", bus.busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int ox, oy, w, h;
    n_cmp = 0;
    n_bad = 0;
    rst_ = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_origx  = '0;
    bus.cmd_origy  = '0;
    bus.cmd_width  = '0;
    bus.cmd_height = '0;
    bus.addr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_addr_valid", bus.addr_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_word", bus.addr_word, 0);
    chk("reset_eol_last", {bus.addr_eol, bus.addr_last}, 0);
    rst_ = 1'b0;

    run_cmd(0, 0, 2, 1, 0, -1);
    run_cmd(10, 2, 2, 2, 0, -1);
    run_cmd(639, 479, 1, 1, 0, -1);
    run_cmd(10, 2, 2, 2, 1, -1);
    run_cmd(630, 0, 20, 1, 0, -1);
    run_cmd(10, 2, 2, 2, 0, 1);
    run_cmd(5, 5, 3, 2, 0, -1);
    run_cmd(3, 3, 0, 4, 0, -1);
    run_cmd(0, 478, 2, 5, 2, -1);

    for (int i = 0; i < 25; i++) begin
      ox = $urandom_range(0, SCR_W - 1);
      oy = $urandom_range(0, SCR_H - 1);
      w  = $urandom_range(1, 6);
      h  = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) ox = SCR_W - $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) oy = SCR_H - $urandom_range(0, 2);
      run_cmd(ox, oy, w, h, $urandom_range(0, 2), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
